// File: rtl/tri_bus_arbiter.sv
// tri_bus_arbiter: round-robin owner selection for a 4-source tri-state bus, with a bounded hold time and a turnaround cycle between owners
module tri_bus_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [3:0] drv_en,
  output logic       cap_en,
  output logic [1:0] owner,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, GRANT, DRIVE, TURN} state_t;
  localparam logic [2:0] HMAX = 3'(MAX_HOLD - 1);
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, owner_n, sel;
  logic [2:0] hold_cnt, hold_n;
  logic [3:0] gnt_n, drv_n;
  logic cap_n, release_bus;
  always_comb begin
    sel = ptr;
    for (int i = 3; i >= 0; i--) if (req[ptr + 2'(i)]) sel = ptr + 2'(i);
  end
  // an owner gives up the bus when it drops its request, or when it has used its full hold while someone else waits
  always_comb begin
    release_bus = 1'b0;
    state_n = state;
    ptr_n = ptr;
    hold_n = hold_cnt;
    gnt_n = gnt;
    drv_n = drv_en;
    cap_n = cap_en;
    owner_n = owner;
    case (state)
      IDLE: if (|req) begin
        state_n = GRANT;
        gnt_n = 4'b0001 << sel;
        owner_n = sel;
      end
      GRANT: if (req[owner]) begin
        state_n = DRIVE;
        drv_n = gnt;
        cap_n = 1'b1;
        hold_n = 3'd0;
      end else release_bus = 1'b1;
      DRIVE: begin
        hold_n = hold_cnt == HMAX ? hold_cnt : hold_cnt + 3'd1;
        release_bus = !req[owner] || (hold_cnt == HMAX && |(req & ~gnt));
      end
      default: state_n = IDLE;
    endcase
    if (release_bus) begin
      state_n = TURN;
      ptr_n = owner + 2'd1;
      hold_n = 3'd0;
      gnt_n = 4'd0;
      drv_n = 4'd0;
      cap_n = 1'b0;
      owner_n = 2'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      ptr <= 2'd0;
      hold_cnt <= 3'd0;
      gnt <= 4'd0;
      drv_en <= 4'd0;
      cap_en <= 1'b0;
      owner <= 2'd0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      hold_cnt <= hold_n;
      gnt <= gnt_n;
      drv_en <= drv_n;
      cap_en <= cap_n;
      owner <= owner_n;
    end
  end
  assign busy = state != IDLE;
endmodule

// File: doc/tri_bus_arbiter.md
TRI_BUS_ARBITER -- requirements
Module: tri_bus_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4, legal 1..8: maximum DRIVE-state cycles an owner keeps the bus while another requester waits.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-low reset (reset==0 at a posedge clears state).
REQ-004 req  input  4  per-requester bus request, level-held while the bus is wanted.
REQ-005 gnt  output  4  registered one-hot grant; all-zero when no owner.
REQ-006 drv_en  output  4  registered one-hot tri-state drive enable (cntl of the owner's 8 TRI buffers).
REQ-007 cap_en  output  1  registered load enable for the shared 8-bit capture register.
REQ-008 owner  output  2  encoded index of the current owner; 0 when no owner.
REQ-009 busy  output  1  high in every state except IDLE.

Function
REQ-010 States SHALL be IDLE, GRANT, DRIVE, TURN; all outputs SHALL be registered (no combinational path req->outputs).
REQ-011 IDLE: if req!=0, select the first set bit scanning ptr, ptr+1, ... mod 4; next cycle gnt=onehot(sel), owner=sel, state=GRANT; if req==0, remain IDLE.
REQ-012 Latency: req sampled high at edge N -> gnt high after edge N (cycle N+1); drv_en and cap_en high one cycle later.
REQ-013 GRANT lasts exactly one cycle: if req[owner]==1 -> DRIVE with drv_en=gnt, cap_en=1; if req[owner]==0 -> TURN.
REQ-014 DRIVE: hold_cnt (3-bit) SHALL count DRIVE cycles starting at 0 on entry, saturating at MAX_HOLD-1.
REQ-015 DRIVE exit to TURN when req[owner]==0, or when hold_cnt==MAX_HOLD-1 and any other req bit is high; otherwise stay in DRIVE indefinitely.
REQ-016 Entering TURN SHALL clear gnt, drv_en, cap_en in the same edge; TURN lasts one cycle with no driver (bus turnaround), then IDLE.
REQ-017 On each exit from GRANT or DRIVE, ptr SHALL become (owner+1) mod 4 (round-robin fairness).
REQ-018 drv_en SHALL never have more than one bit set, and SHALL be zero in IDLE, GRANT and TURN.
REQ-019 Requests arriving in GRANT/DRIVE/TURN SHALL be held off; arbitration occurs only in IDLE using req at that edge.
REQ-020 MAX_HOLD==1: forced release after first DRIVE cycle whenever another requester is pending.
REQ-021 Minimum bus gap between two owners SHALL be 2 cycles (TURN + IDLE) with drv_en all-zero.

Reset
REQ-022 reset==0 at any posedge, including mid-GRANT/DRIVE, SHALL force state=IDLE, ptr=0, hold_cnt=0, gnt=0, drv_en=0, cap_en=0, owner=0, busy=0 at that edge.
REQ-023 reset SHALL take priority over all requests; first arbitration occurs at the first edge with reset==1.

Verification
REQ-024 Single: reset released, req=4'b0100 held -> gnt=0100 next cycle, drv_en=0100/cap_en=1 the cycle after, owner=2; drop req -> TURN, all zero next cycle, IDLE after.
REQ-025 Round-robin: req=4'b1111 held, MAX_HOLD=4 -> owners in order 0,1,2,3,0; each DRIVE lasts exactly 4 cycles; 2-cycle gap with drv_en=0 between owners.
REQ-026 No contention: MAX_HOLD=4, req=4'b0001 held 10 cycles alone -> owner 0 stays in DRIVE all 10 cycles (no forced release).
REQ-027 Early drop: req=4'b0010 for 1 cycle only -> gnt=0010 for one cycle, drv_en stays 0000, cap_en stays 0, ptr becomes 2.
REQ-028 Reset mid-drive: owner 3 in DRIVE, reset=0 for one edge -> gnt=drv_en=0, owner=0, busy=0; with req=4'b1001 after release, owner 0 granted (ptr reset to 0).
REQ-029 Checker throughout: onehot0(drv_en), drv_en subset of gnt, cap_en==(drv_en!=0).
